// File: rtl/glb_stream_pkg.sv
// -----------------------------------------------------------------------------
// glb_stream_pkg
// Shared definitions for the GLB write-driver / stream-sink pair.
//   GLB_DATA_WIDTH : default stream word width
//   sink_state_t   : sink FSM states (IDLE, RECV, DONE)
// -----------------------------------------------------------------------------
package glb_stream_pkg;

    localparam int GLB_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } sink_state_t;

endpackage

// File: rtl/glb_sink_stall_gen.sv
// -----------------------------------------------------------------------------
// glb_sink_stall_gen
// Phase counter that marks one stall cycle in every STALL_EVERY cycles.
// It knows nothing about the handshake: the owner clears it when a run
// starts and enables it for every cycle spent receiving.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : force the next phase to 0 (takes priority over i_en)
//   i_en         : advance the phase by one
//   o_stall_nxt  : the phase that will be loaded at the coming edge is a
//                  stall phase (lets the owner register its ready flag)
// -----------------------------------------------------------------------------
module glb_sink_stall_gen #(
    parameter int STALL_EVERY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_stall_nxt
);

    generate
        if (STALL_EVERY >= 2) begin : g_cnt
            localparam int PW = $clog2(STALL_EVERY);
            localparam logic [PW-1:0] LAST_PHASE = PW'(STALL_EVERY - 1);

            logic [PW-1:0] r_phase;
            logic [PW-1:0] w_phase_nxt;

            // The counter wraps at STALL_EVERY, so it always holds
            // (cycles since clear) mod STALL_EVERY.
            always_comb begin
                w_phase_nxt = r_phase;
                if (i_clr) begin
                    w_phase_nxt = '0;
                end else if (i_en) begin
                    w_phase_nxt = (r_phase == LAST_PHASE) ? '0 : r_phase + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_phase <= '0;
                end else begin
                    r_phase <= w_phase_nxt;
                end
            end

            assign o_stall_nxt = (w_phase_nxt == LAST_PHASE);
        end else begin : g_none
            logic w_unused;
            assign w_unused    = &{1'b0, clk, rst_n, i_clr, i_en};
            assign o_stall_nxt = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/glb_stream_sink.sv
// -----------------------------------------------------------------------------
// glb_stream_sink
// Consumer of the GLB write driver's valid/ready word stream. Captures
// TX_SIZE words into a local array, keeps a wrapping checksum and raises
// done when the run is complete. Optional periodic backpressure.
// Handshake: a word transfers on a rising edge where valid=1 and ready=1.
// ready is a register, so it never depends on valid or data in the same
// cycle; the source must hold data stable while valid=1 and ready=0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : arm / re-arm pulse (ignored while receiving)
//   data, valid : stream word and its qualifier
//   ready       : sink accepts data this cycle (registered)
//   done        : TX_SIZE words captured (registered)
//   count       : words accepted this run
//   checksum    : sum of accepted words mod 2^DATA_WIDTH
//   rd_addr     : readback address
//   rd_data     : array word at rd_addr (combinational)
//   dbg_state   : current FSM state, for observation only
// -----------------------------------------------------------------------------
module glb_stream_sink
    import glb_stream_pkg::*;
#(
    parameter int TX_SIZE     = 32,
    parameter int DEPTH       = 1024,
    parameter int DATA_WIDTH  = GLB_DATA_WIDTH,
    parameter int STALL_EVERY = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         valid,
    output logic                         ready,
    output logic                         done,
    output logic [$clog2(TX_SIZE+1)-1:0] count,
    output logic [DATA_WIDTH-1:0]        checksum,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [1:0]                   dbg_state
);

    localparam int CW = $clog2(TX_SIZE + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(TX_SIZE - 1);

    generate
        if (STALL_EVERY == 1) begin : g_bad_stall
            $error("glb_stream_sink: STALL_EVERY=1 would stall forever");
        end
        if (TX_SIZE < 1 || TX_SIZE > DEPTH) begin : g_bad_size
            $error("glb_stream_sink: TX_SIZE must be in 1..DEPTH");
        end
    endgenerate

    sink_state_t           r_state;
    sink_state_t           w_state_nxt;
    logic                  r_ready;
    logic                  r_done;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_checksum;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_xfer;
    logic                  w_enter;
    logic                  w_stall_nxt;
    logic [AW-1:0]         w_wr_addr;

    // r_ready is only ever high in RECV, but qualify anyway so the
    // transfer condition reads on its own.
    assign w_xfer    = (r_state == RECV) && valid && r_ready;
    assign w_wr_addr = AW'(r_count);

    // Next-state logic. w_enter marks the edge that (re)starts a run and
    // clears count, checksum and the stall phase. In RECV, start is
    // ignored, so a simultaneous start and transfer takes the transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RECV;
                    w_enter     = 1'b1;
                end
            end
            RECV: begin
                if (w_xfer && (r_count == LAST_IDX)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = RECV;
                    w_enter     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    glb_sink_stall_gen #(
        .STALL_EVERY (STALL_EVERY)
    ) u_stall (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_enter),
        .i_en        (r_state == RECV),
        .o_stall_nxt (w_stall_nxt)
    );

    // ready/done are derived from the next state and next phase so they
    // line up with the state they describe: ready rises on the start edge
    // and drops on the last-transfer edge, so no extra word slips in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == RECV) && !w_stall_nxt;
            r_done  <= (w_state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_checksum <= '0;
        end else if (w_enter) begin
            r_count    <= '0;
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_count    <= r_count + 1'b1;
            r_checksum <= r_checksum + data;
        end
    end

    // Capture array is deliberately not reset; stale words stay readable.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[w_wr_addr] <= data;
        end
    end

    assign rd_data   = r_mem[rd_addr];
    assign ready     = r_ready;
    assign done      = r_done;
    assign count     = r_count;
    assign checksum  = r_checksum;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_glb_stream_sink.sv
// Self-checking bench for glb_stream_sink. Three instances cover the
// default configuration, periodic backpressure and a single-word run;
// a monitor compares the selected instance every cycle against a
// behavioural model fed by the expected-word queue.
module tb_glb_stream_sink;
    import glb_stream_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start4 = 1'b0, start1 = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic [9:0]  rd_addr = '0;

    logic        ready0, done0, ready4, done4, ready1, done1;
    logic [5:0]  count0, count4;
    logic [0:0]  count1;
    logic [15:0] sum0, sum4, sum1, rd0, rd4, rd1;
    logic [1:0]  st0, st4, st1;

    glb_stream_sink #(.TX_SIZE(32), .DEPTH(1024), .DATA_WIDTH(16), .STALL_EVERY(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .data(data), .valid(valid),
        .ready(ready0), .done(done0), .count(count0), .checksum(sum0),
        .rd_addr(rd_addr), .rd_data(rd0), .dbg_state(st0));

    glb_stream_sink #(.TX_SIZE(32), .DEPTH(1024), .DATA_WIDTH(16), .STALL_EVERY(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .data(data), .valid(valid),
        .ready(ready4), .done(done4), .count(count4), .checksum(sum4),
        .rd_addr(rd_addr), .rd_data(rd4), .dbg_state(st4));

    glb_stream_sink #(.TX_SIZE(1), .DEPTH(1024), .DATA_WIDTH(16), .STALL_EVERY(0)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data(data), .valid(valid),
        .ready(ready1), .done(done1), .count(count1), .checksum(sum1),
        .rd_addr(rd_addr), .rd_data(rd1), .dbg_state(st1));

    // Selected instance: 0 -> u_s0, 1 -> u_s4, 2 -> u_s1
    int          sel = 0;
    logic        ready_m, done_m, start_m;
    logic [5:0]  count_m;
    logic [15:0] sum_m, rd_m;
    logic [1:0]  st_m;

    always_comb begin
        ready_m = ready0; done_m = done0; start_m = start0;
        count_m = count0; sum_m = sum0; rd_m = rd0; st_m = st0;
        case (sel)
            1: begin
                ready_m = ready4; done_m = done4; start_m = start4;
                count_m = count4; sum_m = sum4; rd_m = rd4; st_m = st4;
            end
            2: begin
                ready_m = ready1; done_m = done1; start_m = start1;
                count_m = {5'b0, count1}; sum_m = sum1; rd_m = rd1; st_m = st1;
            end
            default: ;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t sel=%0d)", nm, act, exp, $time, sel);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 receiving, 2 finished. m_phase counts cycles since
    // the run started; the spec's stall rule is applied arithmetically.
    logic [15:0] exp_q[$];
    int          m_mode = 0;
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;
    logic [15:0] m_mem [1024];

    function automatic int tx_of(input int s);
        return (s == 2) ? 1 : 32;
    endfunction

    function automatic int n_of(input int s);
        return (s == 1) ? 4 : 0;
    endfunction

    function automatic logic m_ready();
        int n;
        n = n_of(sel);
        if (m_mode != 1) return 1'b0;
        if (n == 0) return 1'b1;
        return ((m_phase % n) != (n - 1));
    endfunction

    task automatic model_clear();
        m_mode = 0; m_phase = 0; m_cnt = 0; m_sum = '0;
    endtask

    // Monitor: compare the current outputs, then advance the model with
    // the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        logic [15:0] w;
        if (!rst_n) model_clear();
        check("mon_ready", {31'b0, ready_m}, {31'b0, m_ready()});
        check("mon_done", {31'b0, done_m}, (m_mode == 2) ? 1 : 0);
        check("mon_count", {26'b0, count_m}, m_cnt);
        check("mon_checksum", {16'b0, sum_m}, {16'b0, m_sum});
        if (rst_n) begin
            case (m_mode)
                0, 2: begin
                    if (start_m) begin
                        m_mode = 1; m_phase = 0; m_cnt = 0; m_sum = '0;
                    end
                end
                default: begin
                    if (valid && m_ready()) begin
                        if (exp_q.size() == 0) begin
                            check("mon_queue_empty", 1, 0);
                        end else begin
                            w = exp_q.pop_front();
                            m_mem[m_cnt] = w;
                            m_cnt++;
                            m_sum = m_sum + w;
                        end
                    end
                    if (m_cnt == tx_of(sel)) m_mode = 2;
                    else m_phase++;
                end
            endcase
        end
    end

    // ---------------- driver tasks (enter/leave at posedge+1) ----------------
    task automatic send(input logic [15:0] w);
        int t;
        data = w;
        valid = 1'b1;
        exp_q.push_back(w);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ready_m && t < 200);
        if (!ready_m) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // mode 0: ramp 0..n-1, mode 1: random. valid drops for 3 cycles after
    // word index gap_after (use -1 for none).
    task automatic stream(input int n, input int mode, input int gap_after);
        for (int i = 0; i < n; i++) begin
            send(mode == 0 ? 16'(i) : 16'($urandom_range(0, 65535)));
            if (i == gap_after) begin
                valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    @(posedge clk);
                    #1;
                    check("gap_count_hold", {26'b0, count_m}, i + 1);
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start0 = 1'b1;
        if (which == 1) start4 = 1'b1;
        if (which == 2) start1 = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start0 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 10'(i);
            #1;
            check("rd_data", {16'b0, rd_m}, {16'b0, m_mem[i]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // -------- reset --------
        #23;
        check("rst_ready0", {31'b0, ready0}, 0);
        check("rst_done0", {31'b0, done0}, 0);
        check("rst_count0", {26'b0, count0}, 0);
        check("rst_sum0", {16'b0, sum0}, 0);
        check("rst_ready4", {31'b0, ready4}, 0);
        check("rst_count4", {26'b0, count4}, 0);
        check("rst_done1", {31'b0, done1}, 0);
        check("rst_state0", {30'b0, st0}, 32'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // -------- run 1: ramp, no stall --------
        sel = 0;
        model_clear();
        pulse_start(0);
        check("start_ready", {31'b0, ready_m}, 1);
        stream(32, 0, -1);
        check("done_latency_n0", cyc - t0, 32);
        check("done_n0", {31'b0, done_m}, 1);
        check("count_n0", {26'b0, count_m}, 32);
        check("checksum_n0", {16'b0, sum_m}, 32'h01F0);
        rd_addr = 10'd5;
        #1;
        check("rd5", {16'b0, rd_m}, 32'h0005);

        // -------- DONE ignores valid --------
        data = 16'hBEEF;
        valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        valid = 1'b0;
        check("done_hold_count", {26'b0, count_m}, 32);
        check("done_hold_sum", {16'b0, sum_m}, 32'h01F0);
        check_mem(32);

        // -------- re-arm, random data with a valid gap --------
        pulse_start(0);
        check("rearm_done", {31'b0, done_m}, 0);
        check("rearm_count", {26'b0, count_m}, 0);
        check("rearm_sum", {16'b0, sum_m}, 0);
        stream(32, 1, 10);
        check("done_run2", {31'b0, done_m}, 1);
        check_mem(32);

        // -------- STALL_EVERY=4 --------
        sel = 1;
        model_clear();
        pulse_start(1);
        stream(32, 0, -1);
        check("done_latency_n4", cyc - t0, 42);
        check("checksum_n4", {16'b0, sum_m}, 32'h01F0);
        check_mem(32);

        // -------- asynchronous reset mid-run --------
        pulse_start(1);
        stream(16, 1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'b0, ready_m}, 0);
        check("arst_done", {31'b0, done_m}, 0);
        check("arst_count", {26'b0, count_m}, 0);
        check("arst_sum", {16'b0, sum_m}, 0);
        check("arst_state", {30'b0, st_m}, 32'(IDLE));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            check("post_rst_ready", {31'b0, ready_m}, 0);
        end
        valid = 1'b0;

        // -------- TX_SIZE=1 --------
        sel = 2;
        model_clear();
        pulse_start(2);
        send(16'hA5A5);
        valid = 1'b0;
        check("done_latency_tx1", cyc - t0, 1);
        check("done_tx1", {31'b0, done_m}, 1);
        check("checksum_tx1", {16'b0, sum_m}, 32'hA5A5);
        check_mem(1);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
